// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared definitions for the clock-divider controller slice:
//   FSM state encoding, the smallest legal divisor and the default
//   counter width.
package clk_div_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if
//   Bundles the run enable, the divisor config handshake and the
//   divider outputs.
//   master: drives en / cfg_valid / cfg_div, observes everything else.
//   slave : the divider controller itself.
interface clk_div_ctrl_if import clk_div_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
);

  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tick;
  logic             clk_out;
  logic [CNT_W-1:0] cur_div;
  logic             busy;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, tick, clk_out, cur_div, busy
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, tick, clk_out, cur_div, busy
  );

endinterface

// File: rtl/clk_div_core.sv
// clk_div_core
//   Period counter plus registered tick / clk_out generation.
//   Ports:
//     clk, rst  : system clock, asynchronous active-high reset
//     run       : controller is counting this cycle (RUN or PEND)
//     run_next  : controller will be counting next cycle
//     cur_div   : divisor in effect this cycle
//     div_next  : divisor in effect next cycle
//     last      : this cycle is the final cycle of the period (k == N-1)
//     tick      : one-cycle enable on k == N-1
//     clk_out   : high for k < N/2
//   Outputs are registered from the next-count value so they line up
//   with the period cycle k they describe.
module clk_div_core import clk_div_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             run_next,
  input  logic [CNT_W-1:0] cur_div,
  input  logic [CNT_W-1:0] div_next,
  output logic             last,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tick_reg, clk_out_reg;

  assign last = run && (cnt_reg == cur_div - ONE);

  // The first counting cycle after IDLE is k=0, so the counter only
  // advances when it was already counting in the current cycle.
  always_comb begin
    cnt_next = cnt_reg + ONE;
    if (!run_next || !run || last) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      tick_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      tick_reg    <= run_next && (cnt_next == div_next - ONE);
      clk_out_reg <= run_next && (cnt_next < (div_next >> 1));
    end
  end

  assign tick    = tick_reg;
  assign clk_out = clk_out_reg;

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Run-time programmable clock-enable generator. Owns the IDLE/RUN/PEND
//   FSM, the divisor config handshake and the current/pending divisor
//   registers; the period counter lives in clk_div_core.
//   Ports:
//     clk, rst : system clock, asynchronous active-high reset
//     bus      : clk_div_ctrl_if.slave (en, cfg_valid/cfg_div/cfg_ready,
//                cfg_err, tick, clk_out, cur_div, busy)
//   A new divisor only takes effect at a period boundary (or when the
//   block is idle / being disabled), so no output period is truncated.
//   DEFAULT_DIV must be >= 2.
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 50
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_PEND = PEND;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cur_div_reg, cur_div_next;
  logic [CNT_W-1:0] pend_div_reg, pend_div_next;
  logic             cfg_ready_reg;
  logic             cfg_err_reg, cfg_err_next;

  logic xfer, legal, run, run_next, last;

  assign xfer     = bus.cfg_valid && cfg_ready_reg;
  assign legal    = bus.cfg_div >= CNT_W'(MIN_DIV);
  assign run      = (state_reg == S_RUN) || (state_reg == S_PEND);
  assign run_next = (state_next != S_IDLE);

  always_comb begin
    state_next    = state_reg;
    cur_div_next  = cur_div_reg;
    pend_div_next = pend_div_reg;
    cfg_err_next  = xfer && !legal;

    if (!bus.en) begin
      // Disabling never loses a divisor: a pending one is committed,
      // and a same-cycle transfer goes straight into effect.
      state_next = S_IDLE;
      if (state_reg == S_PEND) begin
        cur_div_next = pend_div_reg;
      end
      if (xfer && legal) begin
        cur_div_next = bus.cfg_div;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_RUN;
          if (xfer && legal) begin
            cur_div_next = bus.cfg_div;
          end
        end
        S_RUN: begin
          if (xfer && legal) begin
            if (last) begin
              cur_div_next = bus.cfg_div;
            end else begin
              pend_div_next = bus.cfg_div;
              state_next    = S_PEND;
            end
          end
        end
        S_PEND: begin
          if (last) begin
            cur_div_next = pend_div_reg;
            state_next   = S_RUN;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cur_div_reg   <= CNT_W'(DEFAULT_DIV);
      pend_div_reg  <= '0;
      cfg_ready_reg <= 1'b1;
      cfg_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_div_reg   <= cur_div_next;
      pend_div_reg  <= pend_div_next;
      cfg_ready_reg <= (state_next != S_PEND);
      cfg_err_reg   <= cfg_err_next;
    end
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .run_next (run_next),
    .cur_div  (cur_div_reg),
    .div_next (cur_div_next),
    .last     (last),
    .tick     (bus.tick),
    .clk_out  (bus.clk_out)
  );

  assign bus.cfg_ready = cfg_ready_reg;
  assign bus.cfg_err   = cfg_err_reg;
  assign bus.cur_div   = cur_div_reg;
  assign bus.busy      = (state_reg == S_PEND);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl
//   Scoreboard bench: every stimulus cycle advances a period-level
//   reference model and queues the outputs expected after the next clock
//   edge; an independent monitor pops and compares on each falling edge.
module tb_clk_div_ctrl;

  typedef struct packed {
    logic        tick;
    logic        clk_out;
    logic [15:0] cur_div;
    logic        busy;
    logic        cfg_ready;
    logic        cfg_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.CNT_W(16)) bus ();

  clk_div_ctrl #(.CNT_W(16), .DEFAULT_DIV(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: whether the divider is running, the position k in
  // the current period, the period length N, and a pending N (-1: none).
  bit m_active;
  int m_k;
  int m_n;
  int m_pend;
  bit m_err;

  exp_t q[$];
  event rst_chk;
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_n      = 50;
    m_pend   = -1;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit v, input int d);
    bit xfer;
    bit ok;
    xfer  = v && (m_pend < 0);
    ok    = xfer && (d >= 2);
    m_err = xfer && (d < 2);
    if (!e) begin
      if (m_pend >= 0) m_n = m_pend;
      if (ok) m_n = d;
      m_pend   = -1;
      m_active = 1'b0;
      m_k      = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_k      = 0;
      if (ok) m_n = d;
    end else if (m_k == m_n - 1) begin
      if (m_pend >= 0) m_n = m_pend;
      else if (ok)     m_n = d;
      m_pend = -1;
      m_k    = 0;
    end else begin
      m_k = m_k + 1;
      if (ok) m_pend = d;
    end
  endtask

  function automatic exp_t model_out();
    exp_t r;
    r.tick      = m_active && (m_k == m_n - 1);
    r.clk_out   = m_active && (m_k < m_n / 2);
    r.cur_div   = 16'(m_n);
    r.busy      = (m_pend >= 0);
    r.cfg_ready = (m_pend < 0);
    r.cfg_err   = m_err;
    return r;
  endfunction

  // One clock of stimulus. Inputs change 1 time unit after a rising
  // edge; the expectation is queued just after the edge that samples them.
  task automatic step(input bit e, input bit v, input int d);
    bus.en        = e;
    bus.cfg_valid = v;
    bus.cfg_div   = d[15:0];
    if (!rst) model_step(e, v, d);
    @(posedge clk);
    #1;
    q.push_back(model_out());
  endtask

  task automatic run_to_k(input int target);
    int budget;
    budget = 2000;
    while (!(m_active && m_k == target)) begin
      if (budget == 0) begin
        $display("FAIL run_to_k: k=%0d never reached %0d (N=%0d)", m_k, target, m_n);
        $fatal(1, "stimulus sequencing lost");
      end
      step(1'b1, 1'b0, 0);
      budget--;
    end
  endtask

  // Asynchronous reset between edges, checked immediately, then held.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    model_reset();
    q.delete();
    q.push_back(model_out());
    #1;
    -> rst_chk;
    repeat (hold) step(1'b1, 1'b0, 0);
    rst = 1'b0;
  endtask

  // Monitor: falling edges compare the next queued expectation; the
  // rst_chk event (raised while clk is high) checks reset values at once.
  initial begin
    exp_t got;
    exp_t want;
    forever begin
      @(negedge clk or rst_chk);
      got = {bus.tick, bus.clk_out, bus.cur_div, bus.busy, bus.cfg_ready, bus.cfg_err};
      if (clk) begin
        want = '{tick: 1'b0, clk_out: 1'b0, cur_div: 16'd50,
                 busy: 1'b0, cfg_ready: 1'b1, cfg_err: 1'b0};
        n_vec++;
        if (got !== want) begin
          n_mis++;
          $display("FAIL async_reset t=%0t: got tick=%b clk_out=%b cur_div=%0d busy=%b ready=%b err=%b, want tick=%b clk_out=%b cur_div=%0d busy=%b ready=%b err=%b",
                   $time, got.tick, got.clk_out, got.cur_div, got.busy, got.cfg_ready, got.cfg_err,
                   want.tick, want.clk_out, want.cur_div, want.busy, want.cfg_ready, want.cfg_err);
        end
      end else if (q.size() > 0) begin
        want = q.pop_front();
        n_vec++;
        if (got !== want) begin
          n_mis++;
          $display("FAIL cycle t=%0t: got tick=%b clk_out=%b cur_div=%0d busy=%b ready=%b err=%b, want tick=%b clk_out=%b cur_div=%0d busy=%b ready=%b err=%b",
                   $time, got.tick, got.clk_out, got.cur_div, got.busy, got.cfg_ready, got.cfg_err,
                   want.tick, want.clk_out, want.cur_div, want.busy, want.cfg_ready, want.cfg_err);
        end
      end
    end
  end

  initial begin
    int r;
    int d;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    model_reset();

    // Held in reset, then released and run with the default divisor.
    repeat (3) step(1'b0, 1'b0, 0);
    rst = 1'b0;
    repeat (120) step(1'b1, 1'b0, 0);

    // Mid-period request: pends until the end of the 50-cycle period.
    run_to_k(10);
    step(1'b1, 1'b1, 500);
    repeat (560) step(1'b1, 1'b0, 0);

    // Requests landing exactly on the final period cycle apply directly.
    run_to_k(499);
    step(1'b1, 1'b1, 50);
    run_to_k(49);
    step(1'b1, 1'b1, 500);
    repeat (520) step(1'b1, 1'b0, 0);

    // Illegal divisors are rejected with a one-cycle error pulse.
    run_to_k(100);
    step(1'b1, 1'b1, 1);
    repeat (3) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    repeat (5) step(1'b1, 1'b0, 0);

    // Pending divisor committed by dropping en, then run with N=7.
    run_to_k(5);
    step(1'b1, 1'b1, 7);
    step(1'b0, 1'b0, 0);
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (30) step(1'b1, 1'b0, 0);

    // Back to N=500, then asynchronous reset at k=20.
    run_to_k(6);
    step(1'b1, 1'b1, 500);
    run_to_k(20);
    do_reset(2);
    repeat (60) step(1'b1, 1'b0, 0);

    // Largest divisor loaded while idle with en low.
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 65535);
    repeat (20) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // Randomised traffic with small divisors so many boundaries occur.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       d = 0;
        1:       d = 1;
        2:       d = 2;
        3:       d = 3;
        4, 5, 6: d = $urandom_range(2, 20);
        default: d = $urandom_range(2, 60);
      endcase
      if ($urandom_range(0, 599) == 0) do_reset(1);
      step($urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0, d);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
